// File: rtl/fifo_half_duplex_uart.sv
// Half-duplex ISO7816 UART: one shared line, TX and RX FIFOs, self-timed bit clock.
// Define T0_ERROR_SIGNAL_EN to enable T=0 error signalling and character repetition.

module UartFifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0]    mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0] wrPtr;
    logic [ADDR_WIDTH:0] rdPtr;
    logic                doPush;
    logic                doPop;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]) &&
                      (wrPtr[ADDR_WIDTH-1:0] == rdPtr[ADDR_WIDTH-1:0]);
    assign doPop    = pop && !empty;
    // A pop frees the head slot in the same cycle, so a push alongside it is accepted even when full.
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[ADDR_WIDTH-1:0]] <= pushData;
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end
endmodule

module fifo_half_duplex_uart #(
    parameter int DATA_WIDTH          = 8,
    parameter int FIFO_DEPTH_LOG2     = 3,
    parameter int CLOCK_PER_BIT_WIDTH = 13,
    parameter int MAX_RETRIES         = 4
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic                           serialIn,
    output logic                           serialOut,
    output logic                           isTx,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    input  logic                           stopBit2,
    input  logic                           oddParity,
    input  logic                           msbFirst,
    input  logic [DATA_WIDTH-1:0]          txData,
    input  logic                           txWrite,
    output logic                           txFull,
    output logic                           txEmpty,
    output logic [DATA_WIDTH-1:0]          rxData,
    input  logic                           rxRead,
    output logic                           rxEmpty,
    output logic                           rxOverrun,
    output logic                           frameError,
    output logic                           parityError,
    output logic                           txError,
    input  logic                           ackFlags,
    output logic                           busy
);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CW = CLOCK_PER_BIT_WIDTH;

    typedef enum logic [3:0] {
        IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP,
        TX_START, TX_DATA, TX_PARITY, TX_STOP, ERR_SIG, TX_GUARD
    } uartState_t;

    uartState_t            state, stateNext;
    logic [CW-1:0]         bitCount, bitCountNext;
    logic [CW-1:0]         cpbReg, cpbNext;
    logic [IW-1:0]         bitIdx, bitIdxNext;
    logic [IW-1:0]         dataPos;
    logic                  phase, phaseNext;
    logic                  cfgStop2, stop2Next;
    logic                  cfgOdd, oddNext;
    logic                  cfgMsb, msbNext;
    logic [DATA_WIDTH-1:0] txShift, txShiftNext;
    logic [DATA_WIDTH-1:0] rxShift, rxShiftNext;
    logic                  parityBad, parityBadNext;
    logic [1:0]            syncReg;
    logic                  rxLine;
    logic                  bitDone;
    logic                  midPoint;
    logic                  txPop, rxPush;
    logic                  setFrame, setParity, setOverrun, setTxError;
    logic [DATA_WIDTH-1:0] txHead;
    logic                  txFifoEmpty;
    logic                  rxFull;
    logic                  rxCanPush;
`ifdef T0_ERROR_SIGNAL_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic [RW-1:0]         retryCount, retryNext;
    logic                  txErrorReg;
`endif

    UartFifo #(.WIDTH(DATA_WIDTH), .ADDR_WIDTH(FIFO_DEPTH_LOG2)) txFifo (
        .clk(clk), .nReset(nReset), .push(txWrite), .pushData(txData), .pop(txPop),
        .headData(txHead), .full(txFull), .empty(txFifoEmpty)
    );

    UartFifo #(.WIDTH(DATA_WIDTH), .ADDR_WIDTH(FIFO_DEPTH_LOG2)) rxFifo (
        .clk(clk), .nReset(nReset), .push(rxPush), .pushData(rxShift), .pop(rxRead),
        .headData(rxData), .full(rxFull), .empty(rxEmpty)
    );

    assign rxLine    = syncReg[1];
    assign bitDone   = (bitCount == cpbReg - 1'b1);
    assign midPoint  = (bitCount == (cpbReg >> 1));
    assign dataPos   = cfgMsb ? (IW'(DATA_WIDTH - 1) - bitIdx) : bitIdx;
    assign rxCanPush = !rxFull || (rxRead && !rxEmpty);
    assign busy      = (state != IDLE);
    assign txEmpty   = txFifoEmpty && !(state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_GUARD});

    // Our own transmission is masked out of the synchroniser so it never echoes back as a start bit.
    always_ff @(posedge clk) begin
        if (!nReset) syncReg <= 2'b11;
        else         syncReg <= {syncReg[0], isTx ? 1'b1 : serialIn};
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state     <= IDLE;
            bitCount  <= '0;
            cpbReg    <= '0;
            bitIdx    <= '0;
            phase     <= 1'b0;
            cfgStop2  <= 1'b0;
            cfgOdd    <= 1'b0;
            cfgMsb    <= 1'b0;
            txShift   <= '0;
            rxShift   <= '0;
            parityBad <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCount  <= bitCountNext;
            cpbReg    <= cpbNext;
            bitIdx    <= bitIdxNext;
            phase     <= phaseNext;
            cfgStop2  <= stop2Next;
            cfgOdd    <= oddNext;
            cfgMsb    <= msbNext;
            txShift   <= txShiftNext;
            rxShift   <= rxShiftNext;
            parityBad <= parityBadNext;
        end
    end

    // Sticky flags: a set event in the same cycle as ackFlags wins.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            rxOverrun   <= 1'b0;
            frameError  <= 1'b0;
            parityError <= 1'b0;
        end else begin
            rxOverrun   <= setOverrun | (rxOverrun & ~ackFlags);
            frameError  <= setFrame   | (frameError & ~ackFlags);
            parityError <= setParity  | (parityError & ~ackFlags);
        end
    end

`ifdef T0_ERROR_SIGNAL_EN
    always_ff @(posedge clk) begin
        if (!nReset) begin
            retryCount <= '0;
            txErrorReg <= 1'b0;
        end else begin
            retryCount <= retryNext;
            txErrorReg <= setTxError | (txErrorReg & ~ackFlags);
        end
    end
    assign txError = txErrorReg;
`else
    // Without repetition there is no retry budget to exhaust; this is constant low for any legal MAX_RETRIES.
    assign txError = (MAX_RETRIES < 0);
`endif

    // `phase` selects the second stop bit, the idle half of ERR_SIG, or the second guard bit.
    always_comb begin
        stateNext     = state;
        bitCountNext  = '0;
        cpbNext       = cpbReg;
        bitIdxNext    = bitIdx;
        phaseNext     = phase;
        stop2Next     = cfgStop2;
        oddNext       = cfgOdd;
        msbNext       = cfgMsb;
        txShiftNext   = txShift;
        rxShiftNext   = rxShift;
        parityBadNext = parityBad;
        txPop         = 1'b0;
        rxPush        = 1'b0;
        setFrame      = 1'b0;
        setParity     = 1'b0;
        setOverrun    = 1'b0;
        setTxError    = 1'b0;
        serialOut     = 1'b1;
        isTx          = 1'b0;
`ifdef T0_ERROR_SIGNAL_EN
        retryNext     = retryCount;
`endif
        if (state != IDLE) bitCountNext = bitDone ? '0 : bitCount + 1'b1;

        case (state)
            IDLE: begin
                cpbNext       = clocksPerBit;
                stop2Next     = stopBit2;
                oddNext       = oddParity;
                msbNext       = msbFirst;
                bitIdxNext    = '0;
                phaseNext     = 1'b0;
                parityBadNext = 1'b0;
                // A start bit still inside the synchroniser blocks TX, so a simultaneous RX start wins.
                if (!rxLine) begin
                    stateNext = RX_START;
                end else if (!txFifoEmpty && syncReg[0]) begin
                    stateNext   = TX_START;
                    txShiftNext = txHead;
`ifdef T0_ERROR_SIGNAL_EN
                    retryNext   = '0;
`else
                    txPop       = 1'b1;
`endif
                end
            end
            RX_START: begin
                if (midPoint && rxLine) stateNext = IDLE;
                else if (bitDone)       stateNext = RX_DATA;
            end
            RX_DATA: begin
                if (midPoint) rxShiftNext[dataPos] = rxLine;
                if (bitDone) begin
                    if (bitIdx == IW'(DATA_WIDTH - 1)) begin
                        bitIdxNext = '0;
                        stateNext  = RX_PARITY;
                    end else begin
                        bitIdxNext = bitIdx + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (midPoint) parityBadNext = (rxLine != ((^rxShift) ^ cfgOdd));
                if (bitDone) begin
                    phaseNext = 1'b0;
                    stateNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (midPoint && !rxLine) setFrame = 1'b1;
                if (bitDone) begin
                    if (cfgStop2 && !phase) begin
                        phaseNext = 1'b1;
                    end else begin
                        stateNext  = IDLE;
                        setParity  = parityBad;
                        rxPush     = rxCanPush;
                        setOverrun = !rxCanPush;
                    end
                end
`ifdef T0_ERROR_SIGNAL_EN
                if (midPoint && !phase && parityBad) begin
                    stateNext    = ERR_SIG;
                    bitCountNext = '0;
                    phaseNext    = 1'b0;
                    setParity    = 1'b1;
                end
`endif
            end
            TX_START: begin
                isTx      = 1'b1;
                serialOut = 1'b0;
                if (bitDone) begin
                    bitIdxNext = '0;
                    stateNext  = TX_DATA;
                end
            end
            TX_DATA: begin
                isTx      = 1'b1;
                serialOut = txShift[dataPos];
                if (bitDone) begin
                    if (bitIdx == IW'(DATA_WIDTH - 1)) begin
                        bitIdxNext = '0;
                        stateNext  = TX_PARITY;
                    end else begin
                        bitIdxNext = bitIdx + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                isTx      = 1'b1;
                serialOut = (^txShift) ^ cfgOdd;
                if (bitDone) begin
                    phaseNext = 1'b0;
                    stateNext = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bitDone) begin
                    if (cfgStop2 && !phase) begin
                        phaseNext = 1'b1;
                    end else begin
                        stateNext = IDLE;
`ifdef T0_ERROR_SIGNAL_EN
                        txPop     = 1'b1;
`endif
                    end
                end
`ifdef T0_ERROR_SIGNAL_EN
                // The receiver NACKs by holding the line low through the first stop bit.
                if (midPoint && !phase && !rxLine) begin
                    stateNext    = TX_GUARD;
                    bitCountNext = '0;
                    phaseNext    = 1'b0;
                end
`endif
            end
`ifdef T0_ERROR_SIGNAL_EN
            ERR_SIG: begin
                isTx      = !phase;
                serialOut = phase;
                if (bitDone) begin
                    if (!phase) phaseNext = 1'b1;
                    else        stateNext = IDLE;
                end
            end
            TX_GUARD: begin
                if (bitDone) begin
                    if (!phase) begin
                        phaseNext = 1'b1;
                    end else if (retryCount == RW'(MAX_RETRIES)) begin
                        txPop      = 1'b1;
                        setTxError = 1'b1;
                        stateNext  = IDLE;
                    end else begin
                        retryNext  = retryCount + 1'b1;
                        phaseNext  = 1'b0;
                        stateNext  = TX_START;
                    end
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end
endmodule
